// File: rtl/constraint_sat_tally.sv
// Tallies constraint-bank results over a run of candidates: satisfying count,
// first satisfying index and a done pulse. Optional per-constraint failure
// histogram on fail_cnt when TALLY_FAIL_HIST_EN is defined.
module constraint_sat_tally #(
  parameter int unsigned N_CONS = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_cand,
  input  logic [N_CONS-1:0]       cons_mask,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_CONS-1:0]       in_cons,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sat_cnt,
  output logic                    first_found,
  output logic [CNT_W-1:0]        first_idx
`ifdef TALLY_FAIL_HIST_EN
  ,
  output logic [N_CONS*CNT_W-1:0] fail_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  sat_q, sat_d;
  logic [CNT_W-1:0]  first_idx_q, first_idx_d;
  logic              found_q, found_d;
  logic [N_CONS-1:0] mask_q, mask_d;
  logic              accept;
  logic              cand_sat;

  // Masked-off constraints read as satisfied, so an all-zero mask passes everything.
  assign accept   = in_valid && (state_q == S_RUN);
  assign cand_sat = &(in_cons | ~mask_q);

  assign in_ready    = (state_q == S_RUN);
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign sat_cnt     = sat_q;
  assign first_found = found_q;
  assign first_idx   = first_idx_q;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    idx_d       = idx_q;
    sat_d       = sat_q;
    first_idx_d = first_idx_q;
    found_d     = found_q;
    mask_d      = mask_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sat_d       = '0;
          first_idx_d = '0;
          found_d     = 1'b0;
          idx_d       = '0;
          num_d       = num_cand;
          mask_d      = cons_mask;
          state_d     = (num_cand == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (cand_sat) begin
            if (sat_q != '1) sat_d = sat_q + ONE;
            if (!found_q) begin
              first_idx_d = idx_q;
              found_d     = 1'b1;
            end
          end
          if (idx_q == num_q - ONE) state_d = S_DONE;
          else                      idx_d   = idx_q + ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      idx_q       <= '0;
      sat_q       <= '0;
      first_idx_q <= '0;
      found_q     <= 1'b0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      sat_q       <= sat_d;
      first_idx_q <= first_idx_d;
      found_q     <= found_d;
      mask_q      <= mask_d;
    end
  end

`ifdef TALLY_FAIL_HIST_EN
  logic [CNT_W-1:0] fail_q [N_CONS];
  logic [CNT_W-1:0] fail_d [N_CONS];

  always_comb begin
    for (int unsigned k = 0; k < N_CONS; k++) begin
      fail_d[k] = fail_q[k];
      if (state_q == S_IDLE && start) begin
        fail_d[k] = '0;
      end else if (accept && mask_q[k] && !in_cons[k] && fail_q[k] != '1) begin
        fail_d[k] = fail_q[k] + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_CONS; k++) fail_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CONS; k++) fail_q[k] <= fail_d[k];
    end
  end

  always_comb begin
    fail_cnt = '0;
    for (int unsigned k = 0; k < N_CONS; k++) fail_cnt[k*CNT_W +: CNT_W] = fail_q[k];
  end
`endif

endmodule

// File: tb/tb_constraint_sat_tally.sv
// Bench for constraint_sat_tally: fixed vector table, reset-mid-run and
// randomized runs against a list-based reference model.
module tb_constraint_sat_tally;
  localparam int NC = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_cand;
  logic [NC-1:0] cons_mask;
  logic          in_valid;
  logic          in_ready;
  logic [NC-1:0] in_cons;
  logic          busy;
  logic          done;
  logic [CW-1:0] sat_cnt;
  logic          first_found;
  logic [CW-1:0] first_idx;
`ifdef TALLY_FAIL_HIST_EN
  logic [NC*CW-1:0] fail_cnt;
`endif

  constraint_sat_tally #(.N_CONS(NC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_cand(num_cand),
    .cons_mask(cons_mask), .in_valid(in_valid), .in_ready(in_ready),
    .in_cons(in_cons), .busy(busy), .done(done), .sat_cnt(sat_cnt),
    .first_found(first_found), .first_idx(first_idx)
`ifdef TALLY_FAIL_HIST_EN
    , .fail_cnt(fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [NC-1:0] cons_arr [16];
  int exp_fail [NC];

  typedef struct {
    int            num;
    logic [NC-1:0] mask;
    logic [NC-1:0] c0, c1, c2, c3;
    int            gap;
    int            e_sat;
    int            e_first;
    bit            e_found;
  } vec_t;
  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a candidate satisfies when every masked bit is set; counts cap at all-ones.
  task automatic do_run(input int num, input logic [NC-1:0] mask, input int gap, input bit extra);
    int acc = 0, guard = 0, e_sat = 0, e_first = 0;
    bit e_found = 0;
    logic [NC-1:0] c;
    int cap = (1 << CW) - 1;
    for (int k = 0; k < NC; k++) exp_fail[k] = 0;
    chk("idle_ready", in_ready, 0);
    start = 1; num_cand = CW'(num); cons_mask = mask;
    tick();
    start = 0;
    if (num == 0) begin
      chk("zero_done", done, 1);
      chk("zero_ready", in_ready, 0);
      chk("zero_sat", sat_cnt, 0);
      chk("zero_found", first_found, 0);
      tick();
      chk("zero_done_off", done, 0);
      chk("zero_ready_off", in_ready, 0);
      return;
    end
    chk("run_busy0", busy, 1);
    chk("run_clr_sat", sat_cnt, 0);
    chk("run_clr_found", first_found, 0);
    chk("run_clr_first", first_idx, 0);
    while (acc < num && guard < 400) begin
      guard++;
      in_valid = ($urandom_range(99) >= gap);
      in_cons  = in_valid ? cons_arr[acc] : NC'($urandom);
      if (extra) begin
        start     = ($urandom_range(2) == 0);
        num_cand  = CW'($urandom);
        cons_mask = NC'($urandom);
      end
      tick();
      if (in_valid) begin
        c = cons_arr[acc];
        if ((c & mask) == mask) begin
          if (!e_found) begin e_found = 1; e_first = acc; end
          if (e_sat < cap) e_sat++;
        end
        for (int k = 0; k < NC; k++)
          if (mask[k] && !c[k] && exp_fail[k] < cap) exp_fail[k]++;
        acc++;
      end
      chk("sat_cnt", sat_cnt, e_sat);
      chk("first_found", first_found, e_found);
      chk("first_idx", first_idx, e_first);
      if (acc < num) begin
        chk("busy", busy, 1);
        chk("in_ready", in_ready, 1);
        chk("done_early", done, 0);
      end
    end
    in_valid = 0; start = 0; in_cons = '0;
    if (acc < num) chk("timeout_accepts", acc, num);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_ready", in_ready, 0);
`ifdef TALLY_FAIL_HIST_EN
    for (int k = 0; k < NC; k++) chk("fail_slice", fail_cnt[k*CW +: CW], exp_fail[k]);
`endif
    tick();
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_sat", sat_cnt, e_sat);
    chk("hold_first", first_idx, e_first);
  endtask

  task automatic set_vec(input int i, input int num, input logic [NC-1:0] mask,
                         input logic [NC-1:0] c0, c1, c2, c3, input int gap,
                         input int s, input int f, input bit fd);
    tbl[i].num = num; tbl[i].mask = mask;
    tbl[i].c0 = c0; tbl[i].c1 = c1; tbl[i].c2 = c2; tbl[i].c3 = c3;
    tbl[i].gap = gap; tbl[i].e_sat = s; tbl[i].e_first = f; tbl[i].e_found = fd;
  endtask

  initial begin
    rst = 1; start = 0; num_cand = '0; cons_mask = '0; in_valid = 0; in_cons = '0;
    set_vec(0, 4, 8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'hFF, 0, 3, 0, 1);
    set_vec(1, 3, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 50, 1, 2, 1);
    set_vec(2, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    set_vec(3, 2, 8'h00, 8'h00, 8'h12, 8'h00, 8'h00, 0, 2, 0, 1);
    set_vec(4, 3, 8'hF0, 8'h0F, 8'h1F, 8'hFF, 8'h00, 30, 1, 2, 1);
    set_vec(5, 1, 8'h81, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    set_vec(6, 3, 8'h03, 8'h01, 8'h02, 8'h00, 8'h00, 0, 0, 0, 0);

    tick(); tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_cnt, 0);
    chk("rst_found", first_found, 0);
    chk("rst_first", first_idx, 0);
    rst = 0;
    tick();

    for (int i = 0; i < 7; i++) begin
      cons_arr[0] = tbl[i].c0; cons_arr[1] = tbl[i].c1;
      cons_arr[2] = tbl[i].c2; cons_arr[3] = tbl[i].c3;
      do_run(tbl[i].num, tbl[i].mask, tbl[i].gap, 0);
      chk("tbl_sat", sat_cnt, tbl[i].e_sat);
      chk("tbl_found", first_found, tbl[i].e_found);
      chk("tbl_first", first_idx, tbl[i].e_first);
`ifdef TALLY_FAIL_HIST_EN
      if (i == 6) begin
        chk("hist_k0", fail_cnt[0 +: CW], 2);
        chk("hist_k1", fail_cnt[CW +: CW], 2);
        chk("hist_rest", fail_cnt[NC*CW-1:2*CW], 0);
      end
`endif
    end

    // Reset part-way through a 5-candidate run
    start = 1; num_cand = CW'(5); cons_mask = 8'hFF;
    tick();
    start = 0; in_valid = 1; in_cons = 8'hFF;
    tick(); tick();
    in_valid = 0;
    chk("mid_sat", sat_cnt, 2);
    #2 rst = 1;
    #1;
    chk("async_sat", sat_cnt, 0);
    chk("async_found", first_found, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", in_ready, 0);
    chk("async_done", done, 0);
    @(posedge clk); #1 rst = 0;
    tick();
    chk("post_rst_done", done, 0);
    chk("post_rst_busy", busy, 0);
    for (int j = 0; j < 5; j++) cons_arr[j] = (j == 1 || j == 4) ? 8'hFF : 8'hFE;
    do_run(5, 8'hFF, 20, 0);
    chk("rerun_sat", sat_cnt, 2);
    chk("rerun_first", first_idx, 1);

    // Full-scale runs with stray start pulses while running
    for (int r = 0; r < 2; r++) begin
      logic [NC-1:0] m;
      m = NC'($urandom);
      for (int j = 0; j < 16; j++) cons_arr[j] = m | NC'($urandom);
      do_run(15, m, 25, 1);
      chk("full_sat", sat_cnt, 15);
      repeat (3) tick();
      chk("full_hold", sat_cnt, 15);
    end
    cons_arr[0] = 8'h00;
    do_run(1, 8'hFF, 0, 0);
    chk("clear_sat", sat_cnt, 0);

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      logic [NC-1:0] m;
      int n;
      n = $urandom_range(15);
      m = ($urandom_range(4) == 0) ? 8'h00 : NC'($urandom);
      for (int j = 0; j < 16; j++)
        cons_arr[j] = ($urandom_range(2) == 0) ? NC'($urandom) : (m | NC'($urandom));
      do_run(n, m, $urandom_range(40), $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
